// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths and payload types for the inter-stage pipeline register.
package pipe_stage_reg_pkg;

  typedef struct packed {
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       setflags;
    logic [1:0] mem2reg;
  } ex_mem_ctrl_t;

  localparam int unsigned CTRL_W_DEF = $bits(ex_mem_ctrl_t);
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned N_DATA_DEF = 4;
  localparam int unsigned RD_W_DEF   = 5;
  localparam int unsigned STAGES_DEF = 1;
  localparam int unsigned CNT_W_DEF  = 16;

  // XZR index: a bubble's rd never matches a forwarding or hazard compare.
  localparam logic [RD_W_DEF-1:0] RD_XZR = '1;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Instruction payload moving between pipeline stages: valid, control, rd and data lanes.
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned RD_W   = RD_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_DATA = N_DATA_DEF
) ();

  logic                     valid;
  logic [CTRL_W-1:0]        ctrl;
  logic [RD_W-1:0]          rd;
  logic [N_DATA*DATA_W-1:0] data;

  modport master (output valid, ctrl, rd, data);
  modport slave  (input  valid, ctrl, rd, data);

endinterface

// File: rtl/pipe_stage_reg_slice.sv
// One pipeline slice: load, hold or collapse to a bubble; data is kept through bubbles.
module pipe_stage_reg_slice
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned RD_W   = RD_W_DEF,
  parameter int unsigned DW     = DATA_W_DEF * N_DATA_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic [DW-1:0]     data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [DW-1:0]     data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [RD_W-1:0]   rd_q,    rd_d;
  logic [DW-1:0]     data_q,  data_d;

  // Bubble beats hold; an invalid input still brings its data along.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (bubble_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rd_d    = '1;
    end else if (!hold_i) begin
      data_d = data_i;
      if (valid_i) begin
        valid_d = 1'b1;
        ctrl_d  = ctrl_i;
        rd_d    = rd_i;
      end else begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        rd_d    = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '1;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: STAGES chained slices with stall/flush and a saturating squash counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_DATA = N_DATA_DEF,
  parameter int unsigned RD_W   = RD_W_DEF,
  parameter int unsigned STAGES = STAGES_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam int unsigned DW    = N_DATA * DATA_W;
  localparam int unsigned POP_W = $clog2(STAGES + 1);
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (STAGES < 1) begin : g_bad_stages
    $error("pipe_stage_reg: STAGES must be >= 1");
  end

  logic [STAGES-1:0]             v_q;
  logic [STAGES-1:0][CTRL_W-1:0] c_q;
  logic [STAGES-1:0][RD_W-1:0]   r_q;
  logic [STAGES-1:0][DW-1:0]     d_q;

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    logic              v_src;
    logic [CTRL_W-1:0] c_src;
    logic [RD_W-1:0]   r_src;
    logic [DW-1:0]     d_src;

    if (g == 0) begin : g_head
      assign v_src = in_if.valid;
      assign c_src = in_if.ctrl;
      assign r_src = in_if.rd;
      assign d_src = in_if.data;
    end else begin : g_link
      assign v_src = v_q[g-1];
      assign c_src = c_q[g-1];
      assign r_src = r_q[g-1];
      assign d_src = d_q[g-1];
    end

    pipe_stage_reg_slice #(
      .CTRL_W(CTRL_W),
      .RD_W  (RD_W),
      .DW    (DW)
    ) u_slice (
      .clk     (clk),
      .rst_n   (reset),
      .hold_i  (stall),
      .bubble_i(flush),
      .valid_i (v_src),
      .ctrl_i  (c_src),
      .rd_i    (r_src),
      .data_i  (d_src),
      .valid_o (v_q[g]),
      .ctrl_o  (c_q[g]),
      .rd_o    (r_q[g]),
      .data_o  (d_q[g])
    );
  end

  logic [POP_W-1:0] pop_c;
  logic [SUM_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Number of live instructions a flush on this edge would destroy.
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      pop_c = pop_c + POP_W'(v_q[i]);
    end
  end

  always_comb begin
    sum_c = SUM_W'(cnt_q) + SUM_W'(pop_c);
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = (sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(sum_c);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_if.valid = v_q[STAGES-1];
  assign out_if.ctrl  = c_q[STAGES-1];
  assign out_if.rd    = r_q[STAGES-1];
  assign out_if.data  = d_q[STAGES-1];
  assign squash_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four configurations share one directed stimulus, checked against a slot model.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int unsigned NDUT   = 4;
  localparam int unsigned MAXS   = 3;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned N_DATA = 4;
  localparam int unsigned DW     = N_DATA * DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              valid_in = 1'b0;
  logic [CTRL_W-1:0] ctrl_in = '0;
  logic [RD_W-1:0]   rd_in = '0;
  logic [DW-1:0]     data_in = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic              o_valid [NDUT];
  logic [CTRL_W-1:0] o_ctrl  [NDUT];
  logic [RD_W-1:0]   o_rd    [NDUT];
  logic [DW-1:0]     o_data  [NDUT];
  logic [15:0]       o_cnt   [NDUT];

  // dut0: STAGES=1, dut1: STAGES=2, dut2: STAGES=3, dut3: STAGES=1 with a 2-bit counter
  function automatic int unsigned st_of(input int d);
    return (d == 2) ? 3 : ((d == 1) ? 2 : 1);
  endfunction

  function automatic int unsigned cmax_of(input int d);
    return (d == 3) ? 3 : 65535;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned S_G = (g == 2) ? 3 : ((g == 1) ? 2 : 1);
    localparam int unsigned C_G = (g == 3) ? 2 : 16;

    pipe_stage_reg_if #(.CTRL_W(CTRL_W), .RD_W(RD_W), .DATA_W(DATA_W), .N_DATA(N_DATA)) in_if ();
    pipe_stage_reg_if #(.CTRL_W(CTRL_W), .RD_W(RD_W), .DATA_W(DATA_W), .N_DATA(N_DATA)) out_if ();
    logic [C_G-1:0] cnt;

    assign in_if.valid = valid_in;
    assign in_if.ctrl  = ctrl_in;
    assign in_if.rd    = rd_in;
    assign in_if.data  = data_in;

    pipe_stage_reg #(
      .CTRL_W(CTRL_W), .DATA_W(DATA_W), .N_DATA(N_DATA),
      .RD_W(RD_W), .STAGES(S_G), .CNT_W(C_G)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .flush     (flush),
      .in_if     (in_if),
      .out_if    (out_if),
      .squash_cnt(cnt)
    );

    assign o_valid[g] = out_if.valid;
    assign o_ctrl[g]  = out_if.ctrl;
    assign o_rd[g]    = out_if.rd;
    assign o_data[g]  = out_if.data;
    assign o_cnt[g]   = 16'(cnt);
  end

  // Model: each configuration is a row of instruction slots; the last slot is what the stage presents.
  logic              m_valid [NDUT][MAXS];
  logic [CTRL_W-1:0] m_ctrl  [NDUT][MAXS];
  logic [RD_W-1:0]   m_rd    [NDUT][MAXS];
  logic [DW-1:0]     m_data  [NDUT][MAXS];
  int unsigned       m_cnt   [NDUT];

  function automatic int unsigned live(input int d);
    int unsigned n = 0;
    for (int i = 0; i < int'(st_of(d)); i++) n += m_valid[d][i] ? 1 : 0;
    return n;
  endfunction

  function automatic int unsigned sat(input int d, input int unsigned v);
    return (v > cmax_of(d)) ? cmax_of(d) : v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < NDUT; d++) begin
        m_cnt[d] <= 0;
        for (int i = 0; i < MAXS; i++) begin
          m_valid[d][i] <= 1'b0;
          m_ctrl[d][i]  <= '0;
          m_rd[d][i]    <= 5'd31;
          m_data[d][i]  <= '0;
        end
      end
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        if (flush) begin
          m_cnt[d] <= sat(d, m_cnt[d] + live(d));
          for (int i = 0; i < MAXS; i++) begin
            m_valid[d][i] <= 1'b0;
            m_ctrl[d][i]  <= '0;
            m_rd[d][i]    <= 5'd31;
          end
        end else if (!stall) begin
          for (int i = 1; i < int'(st_of(d)); i++) begin
            m_valid[d][i] <= m_valid[d][i-1];
            m_ctrl[d][i]  <= m_ctrl[d][i-1];
            m_rd[d][i]    <= m_rd[d][i-1];
            m_data[d][i]  <= m_data[d][i-1];
          end
          m_valid[d][0] <= valid_in;
          m_ctrl[d][0]  <= valid_in ? ctrl_in : '0;
          m_rd[d][0]    <= valid_in ? rd_in : 5'd31;
          m_data[d][0]  <= data_in;
        end
      end
    end
  end

  task automatic chk(input string nm, input int d, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    for (int d = 0; d < NDUT; d++) begin
      int unsigned s = st_of(d) - 1;
      chk("valid", d, DW'(o_valid[d]), DW'(m_valid[d][s]));
      chk("ctrl",  d, DW'(o_ctrl[d]),  DW'(m_ctrl[d][s]));
      chk("rd",    d, DW'(o_rd[d]),    DW'(m_rd[d][s]));
      chk("cnt",   d, DW'(o_cnt[d]),   DW'(m_cnt[d]));
      if (m_valid[d][s] || !reset) chk("data", d, o_data[d], m_data[d][s]);
    end
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [RD_W-1:0] r,
                       input logic [DATA_W-1:0] lane, input logic st, input logic fl);
    valid_in = v;
    ctrl_in  = c;
    rd_in    = r;
    data_in  = {N_DATA{lane}};
    stall    = st;
    flush    = fl;
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    compare_model();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [DW-1:0] lanes;

  initial begin
    #1 reset = 1'b0;
    // reset held low with live inputs
    repeat (3) drive(1'b1, 6'h3f, 5'd7, 64'd3333, 1'b0, 1'b0);
    chk("rst_valid", 0, DW'(o_valid[0]), DW'(0));
    chk("rst_ctrl",  0, DW'(o_ctrl[0]),  DW'(0));
    chk("rst_rd",    0, DW'(o_rd[0]),    DW'(31));
    chk("rst_data",  0, o_data[0],       DW'(0));
    chk("rst_cnt",   3, DW'(o_cnt[3]),   DW'(0));
    reset = 1'b1;

    // pass-through, then invalid input becomes a bubble
    drive(1'b1, 6'h3f, 5'd7, 64'd3333, 1'b0, 1'b0);
    lanes = {N_DATA{64'd3333}};
    chk("pt_valid", 0, DW'(o_valid[0]), DW'(1));
    chk("pt_ctrl",  0, DW'(o_ctrl[0]),  DW'(6'h3f));
    chk("pt_rd",    0, DW'(o_rd[0]),    DW'(7));
    chk("pt_data",  0, o_data[0],       lanes);
    drive(1'b0, 6'h3f, 5'd7, 64'd1, 1'b0, 1'b0);
    chk("bub_valid", 0, DW'(o_valid[0]), DW'(0));
    chk("bub_ctrl",  0, DW'(o_ctrl[0]),  DW'(0));
    chk("bub_rd",    0, DW'(o_rd[0]),    DW'(31));

    // stall holds the loaded entry against new inputs
    drive(1'b1, 6'h05, 5'd9, 64'd42, 1'b0, 1'b0);
    lanes = {N_DATA{64'd42}};
    repeat (3) begin
      drive(1'b1, 6'h3f, 5'd1, 64'd99, 1'b1, 1'b0);
      chk("stall_rd",   0, DW'(o_rd[0]), DW'(9));
      chk("stall_data", 0, o_data[0],    lanes);
    end

    // flush beats stall, counting both live slots of the 2-deep stage
    pulse_reset();
    drive(1'b1, 6'h01, 5'd3, 64'd10, 1'b0, 1'b0);
    drive(1'b1, 6'h02, 5'd4, 64'd11, 1'b0, 1'b0);
    chk("fl_pre_rd", 1, DW'(o_rd[1]), DW'(3));
    drive(1'b1, 6'h03, 5'd12, 64'd13, 1'b1, 1'b1);
    chk("fl_valid", 1, DW'(o_valid[1]), DW'(0));
    chk("fl_rd",    1, DW'(o_rd[1]),    DW'(31));
    chk("fl_cnt2",  1, DW'(o_cnt[1]),   DW'(2));
    chk("fl_cnt1",  0, DW'(o_cnt[0]),   DW'(1));

    // 3-deep latency, and one extra edge per stalled cycle
    pulse_reset();
    drive(1'b1, 6'h11, 5'd5, 64'd55, 1'b0, 1'b0);
    chk("lat_e1", 2, DW'(o_valid[2]), DW'(0));
    drive(1'b0, 6'h00, 5'd0, 64'd0, 1'b0, 1'b0);
    chk("lat_e2", 2, DW'(o_valid[2]), DW'(0));
    drive(1'b0, 6'h00, 5'd0, 64'd0, 1'b0, 1'b0);
    chk("lat_e3_valid", 2, DW'(o_valid[2]), DW'(1));
    chk("lat_e3_rd",    2, DW'(o_rd[2]),    DW'(5));
    drive(1'b1, 6'h22, 5'd6, 64'd66, 1'b0, 1'b0);
    drive(1'b0, 6'h00, 5'd0, 64'd0, 1'b0, 1'b0);
    drive(1'b0, 6'h00, 5'd0, 64'd0, 1'b1, 1'b0);
    chk("lat_stall_e3", 2, DW'(o_valid[2]), DW'(0));
    drive(1'b0, 6'h00, 5'd0, 64'd0, 1'b0, 1'b0);
    chk("lat_stall_e4", 2, DW'(o_valid[2]), DW'(1));
    chk("lat_stall_rd", 2, DW'(o_rd[2]),    DW'(6));

    // 2-bit squash counter saturates at 3
    pulse_reset();
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 6'h01, 5'd2, 64'(j), 1'b0, 1'b0);
      drive(1'b0, 6'h00, 5'd0, 64'd0, 1'b0, 1'b1);
      chk("sat_cnt", 3, DW'(o_cnt[3]), DW'((j < 3) ? j + 1 : 3));
    end

    // reset mid-stream discards the in-flight entry immediately
    drive(1'b1, 6'h01, 5'd8, 64'd77, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    compare_model();
    chk("mid_valid", 3, DW'(o_valid[3]), DW'(0));
    chk("mid_cnt",   3, DW'(o_cnt[3]),   DW'(0));
    chk("mid_rd",    3, DW'(o_rd[3]),    DW'(31));
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 6'h01, 5'd8, 64'd77, 1'b0, 1'b0);
    chk("post_valid", 3, DW'(o_valid[3]), DW'(1));
    chk("post_rd",    3, DW'(o_rd[3]),    DW'(8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
